// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use hazard detection with stall/flush control and event counters
module hazard_scoreboard #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_flush,
  output logic              if_id_flush,
  output logic [REG_AW-1:0] ex_mem_rd_q,
  output logic [REG_AW-1:0] mem_wb_rd_q,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            ex_q, mem_q, wb_q;
  slot_t            ex_d;
  logic             haz;
  logic             flush_ex;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // A load in EX whose result an ID source needs cannot be forwarded in time.
  always_comb begin
    haz = id_valid & ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_q.rd != '0) &
          ((ex_q.rd == id_rs1) | (id_uses_rs2 & (ex_q.rd == id_rs2)));
  end

  // A taken branch wins over a stall: the ID instruction is wrong-path and gets squashed.
  assign stall       = haz & ~ex_branch_taken & ~reset;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign flush_ex    = stall | (ex_branch_taken & ~reset);
  assign id_ex_flush = flush_ex;
  assign if_id_flush = ex_branch_taken & ~reset;

  assign ex_mem_rd_q = (~reset & mem_q.valid & mem_q.regwrite) ? mem_q.rd : '0;
  assign mem_wb_rd_q = (~reset & wb_q.valid & wb_q.regwrite) ? wb_q.rd : '0;
  assign stall_count = reset ? '0 : stall_cnt_q;
  assign flush_count = reset ? '0 : flush_cnt_q;

  // Next EX slot: the ID instruction, or a bubble when ID is empty or flushed.
  always_comb begin
    ex_d = '0;
    if (id_valid & ~flush_ex) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  // Advance the shadow pipeline and bump the saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ex_branch_taken && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int CNT_W   = 2;
  localparam int REG_AW  = 5;
  localparam int CNT_CAP = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs1 = '0;
  logic [REG_AW-1:0] id_rs2 = '0;
  logic              id_uses_rs2 = 1'b0;
  logic [REG_AW-1:0] id_rd = '0;
  logic              id_regwrite = 1'b0;
  logic              id_memread = 1'b0;
  logic              ex_branch_taken = 1'b0;
  logic              stall, pc_write, if_id_write, id_ex_flush, if_id_flush;
  logic [REG_AW-1:0] ex_mem_rd_q, mem_wb_rd_q;
  logic [CNT_W-1:0]  stall_count, flush_count;

  hazard_scoreboard #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_branch_taken(ex_branch_taken), .stall(stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_flush(id_ex_flush),
    .if_id_flush(if_id_flush), .ex_mem_rd_q(ex_mem_rd_q), .mem_wb_rd_q(mem_wb_rd_q),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  typedef struct {
    int stall;
    int pc_write;
    int if_id_write;
    int id_ex_flush;
    int if_id_flush;
    int ex_mem_rd;
    int mem_wb_rd;
    int stall_cnt;
    int flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  ins_t hist[$];
  int   m_stall_cnt = 0;
  int   m_flush_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   last_stall = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    ins_t b;
    b = '{v: 0, rd: 0, rw: 0, mr: 0};
    hist = {b, b, b};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endfunction

  // Apply one cycle of ID/branch/reset inputs, predict the outputs, then advance the model.
  task automatic step(input bit v, input int rs1, input int rs2, input bit u2, input int rd,
                      input bit rw, input bit mr, input bit br, input bit rst);
    exp_t e;
    ins_t ex, mem, wb, nxt;
    bit   haz;
    @(posedge clk);
    #1;
    reset = rst; id_valid = v; id_rs1 = rs1[REG_AW-1:0]; id_rs2 = rs2[REG_AW-1:0];
    id_uses_rs2 = u2; id_rd = rd[REG_AW-1:0]; id_regwrite = rw; id_memread = mr;
    ex_branch_taken = br;
    ex  = hist[2];
    mem = hist[1];
    wb  = hist[0];
    haz = v && ex.v && ex.mr && ex.rw && ex.rd != 0 && (ex.rd == rs1 || (u2 && ex.rd == rs2));
    e.stall       = (haz && !br && !rst) ? 1 : 0;
    e.pc_write    = 1 - e.stall;
    e.if_id_write = 1 - e.stall;
    e.id_ex_flush = rst ? 0 : ((e.stall == 1 || br) ? 1 : 0);
    e.if_id_flush = (br && !rst) ? 1 : 0;
    e.ex_mem_rd   = (!rst && mem.v && mem.rw) ? mem.rd : 0;
    e.mem_wb_rd   = (!rst && wb.v && wb.rw) ? wb.rd : 0;
    e.stall_cnt   = rst ? 0 : m_stall_cnt;
    e.flush_cnt   = rst ? 0 : m_flush_cnt;
    exp_q.push_back(e);
    last_stall = (e.stall == 1);
    if (rst) begin
      model_clear();
    end else begin
      if (v && e.id_ex_flush == 0) nxt = '{v: 1, rd: rd, rw: rw, mr: mr};
      else nxt = '{v: 0, rd: 0, rw: 0, mr: 0};
      hist.push_back(nxt);
      void'(hist.pop_front());
      if (e.stall == 1 && m_stall_cnt < CNT_CAP) m_stall_cnt++;
      if (br && m_flush_cnt < CNT_CAP) m_flush_cnt++;
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full output vector; compare it with the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", int'(stall), e.stall);
      chk("pc_write", int'(pc_write), e.pc_write);
      chk("if_id_write", int'(if_id_write), e.if_id_write);
      chk("id_ex_flush", int'(id_ex_flush), e.id_ex_flush);
      chk("if_id_flush", int'(if_id_flush), e.if_id_flush);
      chk("ex_mem_rd_q", int'(ex_mem_rd_q), e.ex_mem_rd);
      chk("mem_wb_rd_q", int'(mem_wb_rd_q), e.mem_wb_rd);
      chk("stall_count", int'(stall_count), e.stall_cnt);
      chk("flush_count", int'(flush_count), e.flush_cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs1, rs2, rd;
    bit v, u2, rw, mr, br, rst;
    model_clear();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(2);
    // load x5; add x6,x5,x1 stalls once, then proceeds
    step(1, 1, 2, 1, 5, 1, 1, 0, 0);
    step(1, 5, 1, 1, 6, 1, 0, 0, 0);
    step(1, 5, 1, 1, 6, 1, 0, 0, 0);
    nop(3);
    // store reading x5 via rs2 stalls; addi with rs2 field 5 unused does not
    step(1, 1, 2, 1, 5, 1, 1, 0, 0);
    step(1, 2, 5, 1, 0, 0, 0, 0, 0);
    step(1, 2, 5, 1, 0, 0, 0, 0, 0);
    step(1, 1, 2, 1, 5, 1, 1, 0, 0);
    step(1, 1, 5, 0, 7, 1, 0, 0, 0);
    nop(3);
    // non-load producer and load to x0 never stall
    step(1, 1, 2, 1, 5, 1, 0, 0, 0);
    step(1, 5, 5, 1, 8, 1, 0, 0, 0);
    step(1, 1, 2, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 9, 1, 0, 0, 0);
    nop(3);
    // back-to-back dependent loads
    step(1, 1, 2, 1, 5, 1, 1, 0, 0);
    step(1, 5, 2, 1, 6, 1, 1, 0, 0);
    step(1, 5, 2, 1, 6, 1, 1, 0, 0);
    step(1, 6, 2, 1, 7, 1, 0, 0, 0);
    step(1, 6, 2, 1, 7, 1, 0, 0, 0);
    nop(3);
    // hazard coinciding with a taken branch after a fresh reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 2, 1, 5, 1, 1, 0, 0);
    step(1, 5, 1, 1, 6, 1, 0, 1, 0);
    nop(3);
    // five separate stalls saturate stall_count
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 2, 1, 4, 1, 1, 0, 0);
      step(1, 4, 3, 0, 6, 1, 0, 0, 0);
      step(1, 4, 3, 0, 6, 1, 0, 0, 0);
      nop(1);
    end
    // reset in the middle of a stall
    step(1, 1, 2, 1, 5, 1, 1, 0, 0);
    step(1, 5, 1, 1, 6, 1, 0, 0, 1);
    nop(3);
    // randomized traffic; ID is held while stalled like a real front end
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        v  = ($urandom_range(0, 9) < 8);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        u2 = $urandom_range(0, 1);
        rd = $urandom_range(0, 7);
        rw = ($urandom_range(0, 9) < 8);
        mr = ($urandom_range(0, 9) < 4);
      end
      br  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(v, rs1, rs2, u2, rd, rw, mr, br, rst);
    end
    nop(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pending_predictions", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
